// File: rtl/register_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// register_arbiter_pkg
//
// Shared definitions for the register access arbiter:
//   state_t    - arbiter FSM states (IDLE / ISSUE / CAPTURE / CLEAR)
//   REG_COUNT  - number of slots in the register unit
//   REG_WIDTH  - default register data width
//   ADDR_WIDTH - default register address width
//   idx_to_onehot - converts a requester index to a one-hot vector
// -----------------------------------------------------------------------------
package register_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    localparam int REG_COUNT  = 16;
    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 4;

    // Widest requester vector the arbiter supports (NUM_REQ is 2..4).
    localparam int MAX_REQ = 4;

    // One-hot encode a requester index; the caller truncates to NUM_REQ bits.
    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/register_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// register_access_arbiter_if
//
// Requester-side bus of the register access arbiter. All requesters share
// one instance; per-requester fields are packed side by side.
//   req   [NUM_REQ]              level request, held until gnt
//   we    [NUM_REQ]              1 = write, 0 = read
//   addr  [NUM_REQ*ADDR_WIDTH]   requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata [NUM_REQ*REG_WIDTH]    requester i at [i*REG_WIDTH +: REG_WIDTH]
//   gnt   [NUM_REQ]              one-hot grant pulse
//   done  [NUM_REQ]              one-hot completion pulse
//   rdata [REG_WIDTH]            read data, valid with done
//   err   [NUM_REQ]              write-protect violation, pulses with done
//                                (only when REG_ARB_WRITE_PROTECT_EN is defined)
//
// Modports: master = requesters, slave = arbiter.
// -----------------------------------------------------------------------------
interface register_access_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*REG_WIDTH-1:0]  wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [REG_WIDTH-1:0]          rdata;
`ifdef REG_ARB_WRITE_PROTECT_EN
    logic [NUM_REQ-1:0]            err;
`endif

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
`ifdef REG_ARB_WRITE_PROTECT_EN
        ,
        input  err
`endif
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
`ifdef REG_ARB_WRITE_PROTECT_EN
        ,
        output err
`endif
    );

endinterface

// File: rtl/register_access_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Combinational round-robin pick. The search starts at the requester just
// after the pointer and wraps, so the last winner has the lowest priority.
//   req [NUM_REQ]  request levels
//   ptr [IDX_W]    index of the previous winner
//   gnt [NUM_REQ]  one-hot winner (all zero when no request)
//   idx [IDX_W]    index of the winner
//   vld            any request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    int               cand_int;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        vld      = 1'b0;
        cand_int = 0;
        cand     = '0;
        // Offsets 1..NUM_REQ: the pointer itself is visited last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_int = int'(ptr) + off;
            if (cand_int >= NUM_REQ) begin
                cand_int = cand_int - NUM_REQ;
            end
            cand = IDX_W'(cand_int);
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_access_arbiter.sv
// -----------------------------------------------------------------------------
// register_access_arbiter
//
// Shares a 16 x REG_WIDTH register unit between NUM_REQ requesters with
// round-robin arbitration, and sequences a whole-unit clear on request.
// Each access takes three cycles: IDLE (pick) -> ISSUE (unit samples
// load/addr) -> CAPTURE (unit data_out valid) and done pulses in the next
// IDLE cycle, which may already pick the following access.
//
// Ports:
//   clock        system clock, posedge
//   reset_n      asynchronous active-low reset
//   bus          requester bus (register_access_arbiter_if.slave)
//   clear_req    pulse: clear all registers (priority over requesters)
//   clear_done   pulse: clear completed
//   rf_reset     register unit reset, active-high, = ~reset_n | clear cycle
//   rf_load      register unit load strobe
//   rf_addr      register unit address
//   rf_data_in   register unit write data
//   rf_data_out  register unit read data (registered inside the unit)
//   wp_mask      per-address write protect (REG_ARB_WRITE_PROTECT_EN only)
//
// Optional feature macro: REG_ARB_WRITE_PROTECT_EN
//   Adds wp_mask and bus.err. Protected writes are granted and completed
//   but never load the unit; err pulses together with done.
// -----------------------------------------------------------------------------
module register_access_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    register_access_arbiter_if.slave    bus,
    input  logic                        clear_req,
    output logic                        clear_done,
    output logic                        rf_reset,
    output logic                        rf_load,
    output logic [ADDR_WIDTH-1:0]       rf_addr,
    output logic [REG_WIDTH-1:0]        rf_data_in,
    input  logic [REG_WIDTH-1:0]        rf_data_out
`ifdef REG_ARB_WRITE_PROTECT_EN
    ,
    input  logic [(1<<ADDR_WIDTH)-1:0]  wp_mask
`endif
);

    import register_arbiter_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    state_t               state_nxt;

    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_nxt;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     cur_idx_nxt;
    logic                 cur_we;
    logic                 cur_we_nxt;
    logic                 pending;
    logic                 pending_nxt;

    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_REQ-1:0]   done_nxt;
    logic [REG_WIDTH-1:0] rdata_q;
    logic [REG_WIDTH-1:0] rdata_nxt;
    logic                 rf_load_nxt;
    logic [ADDR_WIDTH-1:0] rf_addr_nxt;
    logic [REG_WIDTH-1:0] rf_data_in_nxt;
    logic                 clear_done_nxt;

`ifdef REG_ARB_WRITE_PROTECT_EN
    logic                 cur_err;
    logic                 cur_err_nxt;
    logic [NUM_REQ-1:0]   err_q;
    logic [NUM_REQ-1:0]   err_nxt;
`endif

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    logic                 sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [REG_WIDTH-1:0] sel_wdata;
    logic                 sel_blk;
    logic                 clear_pulse;
    logic                 clear_wanted;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_onehot),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Fields of the requester picked this cycle.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = bus.we[i];
                sel_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.wdata[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

`ifdef REG_ARB_WRITE_PROTECT_EN
    assign sel_blk = wp_mask[sel_addr];
`else
    assign sel_blk = 1'b0;
`endif

    // A clear_req seen in IDLE is acted on immediately; elsewhere it waits
    // in pending until the in-flight access has completed.
    assign clear_wanted = pending | clear_req;
    assign clear_pulse  = (state == CLEAR);
    assign rf_reset     = ~reset_n | clear_pulse;

    // ---- state register ----------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clear_wanted) begin
                    state_nxt = CLEAR;
                end else if (pick_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- output / datapath next values -------------------------------------
    always_comb begin
        gnt_nxt        = '0;
        done_nxt       = '0;
        rdata_nxt      = rdata_q;
        rf_load_nxt    = 1'b0;
        rf_addr_nxt    = rf_addr;
        rf_data_in_nxt = rf_data_in;
        clear_done_nxt = 1'b0;
        ptr_nxt        = ptr;
        cur_idx_nxt    = cur_idx;
        cur_we_nxt     = cur_we;
        pending_nxt    = clear_wanted;
`ifdef REG_ARB_WRITE_PROTECT_EN
        cur_err_nxt    = cur_err;
        err_nxt        = '0;
`endif
        case (state)
            IDLE: begin
                if (!clear_wanted && pick_vld) begin
                    gnt_nxt        = pick_onehot;
                    rf_addr_nxt    = sel_addr;
                    rf_data_in_nxt = sel_wdata;
                    rf_load_nxt    = sel_we & ~sel_blk;
                    ptr_nxt        = pick_idx;
                    cur_idx_nxt    = pick_idx;
                    cur_we_nxt     = sel_we;
`ifdef REG_ARB_WRITE_PROTECT_EN
                    cur_err_nxt    = sel_we & sel_blk;
`endif
                end
            end
            CAPTURE: begin
                done_nxt = NUM_REQ'(idx_to_onehot(2'(cur_idx)));
                if (!cur_we) begin
                    rdata_nxt = rf_data_out;
                end
`ifdef REG_ARB_WRITE_PROTECT_EN
                if (cur_err) begin
                    err_nxt = NUM_REQ'(idx_to_onehot(2'(cur_idx)));
                end
`endif
            end
            CLEAR: begin
                clear_done_nxt = 1'b1;
                // clear_req arriving during CLEAR is absorbed.
                pending_nxt    = 1'b0;
            end
            default: ;
        endcase
    end

    // ---- registered outputs and access context -----------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            rf_load    <= 1'b0;
            rf_addr    <= '0;
            rf_data_in <= '0;
            clear_done <= 1'b0;
            ptr        <= IDX_W'(NUM_REQ - 1);
            cur_idx    <= '0;
            cur_we     <= 1'b0;
            pending    <= 1'b0;
`ifdef REG_ARB_WRITE_PROTECT_EN
            cur_err    <= 1'b0;
            err_q      <= '0;
`endif
        end else begin
            gnt_q      <= gnt_nxt;
            done_q     <= done_nxt;
            rdata_q    <= rdata_nxt;
            rf_load    <= rf_load_nxt;
            rf_addr    <= rf_addr_nxt;
            rf_data_in <= rf_data_in_nxt;
            clear_done <= clear_done_nxt;
            ptr        <= ptr_nxt;
            cur_idx    <= cur_idx_nxt;
            cur_we     <= cur_we_nxt;
            pending    <= pending_nxt;
`ifdef REG_ARB_WRITE_PROTECT_EN
            cur_err    <= cur_err_nxt;
            err_q      <= err_nxt;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
`ifdef REG_ARB_WRITE_PROTECT_EN
    assign bus.err   = err_q;
`endif

endmodule

// File: doc/register_access_arbiter.md
Name: register_access_arbiter

Overview:
Shares the 16 x 8-bit register unit between NUM_REQ requesters, for example a CPU port and a debug/loader port. Arbitration is round-robin. Each granted access is sequenced through the register unit's registered load/read timing, and the read data or write completion is returned to the winning requester. The block also sequences a software-requested clear of the whole register unit.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
REG_WIDTH, 8, register data width
ADDR_WIDTH, 4, register address width (16 slots)

Ports:
clock  in  1  system clock, posedge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester access request (level)
we  in  NUM_REQ  per-requester write enable (1=write, 0=read)
addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at [i*4+:4]
wdata  in  NUM_REQ*REG_WIDTH  per-requester write data
gnt  out  NUM_REQ  one-hot grant pulse
done  out  NUM_REQ  one-hot completion pulse
rdata  out  REG_WIDTH  read data, valid with done
clear_req  in  1  pulse: clear all registers
clear_done  out  1  pulse: clear completed
rf_reset  out  1  to register unit reset (active-high)
rf_load  out  1  to register unit load
rf_addr  out  ADDR_WIDTH  to register unit addr
rf_data_in  out  REG_WIDTH  to register unit data_in
rf_data_out  in  REG_WIDTH  from register unit data_out

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; gnt, done, rdata, rf_load, rf_addr, rf_data_in, clear_done = 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - clear pending = 0.
  - rf_reset = ~reset_n | clear_pulse (combinational), so the register unit is held in reset while reset_n is low.
- All other outputs are registered.
- FSM states: IDLE, ISSUE, CAPTURE, CLEAR.
- IDLE transitions:
  - If clear pending -> CLEAR. Clear has priority over all requesters.
  - Else if any req: pick the first requester after the RR pointer, cyclically.
  - On the pick: latch we/addr/wdata; rf_addr<=addr; rf_data_in<=wdata; rf_load<=we; gnt[i]<=1; pointer<=i; -> ISSUE.
- ISSUE (cycle 1): register unit samples load/addr at the end of this cycle. rf_load<=0, gnt<=0 -> CAPTURE.
- CAPTURE (cycle 2): rf_data_out now holds the addressed slot. rdata<=rf_data_out (reads only; rdata is unchanged on writes); done[i]<=1 -> IDLE.
- Latency and throughput:
  - req sampled high in cycle 0 -> gnt in cycle 1 -> done in cycle 3.
  - At most one access per 3 cycles; the IDLE cycle overlaps the done cycle.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until gnt.
  - Requester deasserts req in the cycle after gnt.
  - req high in IDLE after done is a new request.
  - Requests never drop while waiting; a non-granted requester keeps req high.
- Writes: done pulses on completion. rdata is not meaningful for writes. A read issued after a write to the same address returns the new value.
- CLEAR:
  - One cycle; clear_pulse=1 so rf_reset=1; -> IDLE with clear_done<=1 and pending<=0.
  - clear_req arriving during ISSUE/CAPTURE sets pending; the in-flight access completes first.
  - clear_req during CLEAR is absorbed.
- Fairness: with all req held high, grants rotate 0,1,...,NUM_REQ-1,0.
- Reset mid-access: the access is aborted, no done is issued, and the register unit contents are cleared via rf_reset.

Optional Feature:
REG_ARB_WRITE_PROTECT_EN
- With the macro: adds input wp_mask[15:0] and output err[NUM_REQ].
  - A write to an address whose wp_mask bit is 1 is sequenced normally (gnt, done), but rf_load stays 0.
  - err[i] pulses together with done[i] for that write.
  - Reads are never blocked.
- Without the macro: the ports are absent and all writes are performed.

Decomposition:
- Package register_arbiter_pkg: state enum (IDLE/ISSUE/CAPTURE/CLEAR), REG_COUNT=16, REG_WIDTH=8, ADDR_WIDTH=4.
- Sub-module rr_arbiter: combinational round-robin pick from req plus pointer, producing a one-hot grant and an index.

Test Plan:
- Write then read, requester 0: write addr 4'h3 data 8'hA5, then read addr 3 -> gnt[0] in cycle 1, done[0] in cycle 3, read rdata=8'hA5.
- Contention, NUM_REQ=2: both req high continuously for reads of addr 1 and addr 2 -> grant order 0,1,0,1; each rdata matches its own address.
- Clear: write 8'hFF to all 16 slots, pulse clear_req -> rf_reset high exactly 1 cycle, clear_done pulses, all 16 reads return 8'h00.
- Clear during access: clear_req in ISSUE of a write of 8'h5A to addr 7 -> done first, then CLEAR; read addr 7 returns 8'h00.
- Async reset mid-CAPTURE: pull reset_n low -> all outputs 0 immediately, no done; requester 0 wins the first grant after release.
- With REG_ARB_WRITE_PROTECT_EN: wp_mask=16'h0001, write 8'h77 to addr 0 -> err and done pulse together; read addr 0 returns the prior value.
